// File: rtl/exunit_branch_pipe_pkg.sv
// rtl/exunit_branch_pipe_pkg.sv - shared constants, types and spec-tag helpers for the branch pipe
package exunit_branch_pipe_pkg;

    localparam int SPECTAG_LEN  = 5;
    localparam int RRF_SEL      = 6;
    localparam int ALU_OP_WIDTH = 4;

    localparam logic [6:0] RV32_JAL    = 7'b1101111;
    localparam logic [6:0] RV32_JALR   = 7'b1100111;
    localparam logic [6:0] RV32_BRANCH = 7'b1100011;

    typedef enum logic [ALU_OP_WIDTH-1:0] {
        ALU_SEQ  = 4'd0,
        ALU_SNE  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SGE  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_SGEU = 4'd5
    } alu_op_t;

    typedef logic [SPECTAG_LEN-1:0] spectag_t;

    // owntag is the issue-time tag; it is never touched by clear broadcasts
    typedef struct packed {
        spectag_t             owntag;
        logic [RRF_SEL-1:0]   rrftag;
        logic                 dstval;
        logic                 brcond;
        logic                 prsuccess;
    } brq_meta_t;

    typedef struct packed {
        logic     specbit;
        spectag_t mask;
    } spec_state_t;

    function automatic logic spec_killed(spec_state_t st, logic kill_valid, spectag_t kill_mask);
        return kill_valid && st.specbit && (|(st.mask & kill_mask));
    endfunction

    function automatic spec_state_t spec_clear(spec_state_t st, logic clr_valid, spectag_t clr_mask);
        spec_state_t r;
        r = st;
        if (clr_valid) begin
            r.specbit = st.specbit & ~(|(st.mask & clr_mask));
            r.mask    = st.mask & ~clr_mask;
        end
        return r;
    endfunction

endpackage

// File: rtl/exunit_branch_pipe_if.sv
// rtl/exunit_branch_pipe_if.sv - issue, broadcast and writeback signals of the branch pipe
interface exunit_branch_pipe_if
    import exunit_branch_pipe_pkg::*;
#(
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
);
    logic                    issue_valid;
    logic                    issue_ready;
    logic [DATA_LEN-1:0]     ex_src1;
    logic [DATA_LEN-1:0]     ex_src2;
    logic [ADDR_LEN-1:0]     pc;
    logic [ADDR_LEN-1:0]     praddr;
    logic [DATA_LEN-1:0]     imm;
    logic [6:0]              opcode;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic                    is_rvc;
    logic                    dstval;
    logic [RRF_SEL-1:0]      rrftag;
    logic [SPECTAG_LEN-1:0]  spectag;
    logic                    specbit;
    logic                    kill_valid;
    logic [SPECTAG_LEN-1:0]  kill_mask;
    logic                    clr_valid;
    logic [SPECTAG_LEN-1:0]  clr_mask;
    logic                    out_valid;
    logic                    out_ready;
    logic [DATA_LEN-1:0]     result;
    logic [RRF_SEL-1:0]      out_rrftag;
    logic                    rrf_we;
    logic                    rob_we;
    logic                    prsuccess;
    logic                    prmiss;
    logic [ADDR_LEN-1:0]     jmpaddr;
    logic [ADDR_LEN-1:0]     jmpaddr_taken;
    logic                    brcond;
    logic [SPECTAG_LEN-1:0]  tagregfix;

    modport master (
        output issue_valid, ex_src1, ex_src2, pc, praddr, imm, opcode, alu_op, is_rvc,
               dstval, rrftag, spectag, specbit, kill_valid, kill_mask, clr_valid, clr_mask,
               out_ready,
        input  issue_ready, out_valid, result, out_rrftag, rrf_we, rob_we, prsuccess, prmiss,
               jmpaddr, jmpaddr_taken, brcond, tagregfix
    );

    modport slave (
        input  issue_valid, ex_src1, ex_src2, pc, praddr, imm, opcode, alu_op, is_rvc,
               dstval, rrftag, spectag, specbit, kill_valid, kill_mask, clr_valid, clr_mask,
               out_ready,
        output issue_ready, out_valid, result, out_rrftag, rrf_we, rob_we, prsuccess, prmiss,
               jmpaddr, jmpaddr_taken, brcond, tagregfix
    );
endinterface

// File: rtl/exunit_branch_pipe_brq_killfifo.sv
// rtl/exunit_branch_pipe_brq_killfifo.sv - head-ordered FIFO whose entries can be squashed and compacted by spec tag
module exunit_branch_pipe_brq_killfifo
    import exunit_branch_pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PW    = 8,
    parameter int CW    = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_valid,
    input  spec_state_t     push_spec,
    input  logic [PW-1:0]   push_data,
    input  logic            pop_ready,
    input  logic            kill_valid,
    input  spectag_t        kill_mask,
    input  logic            clr_valid,
    input  spectag_t        clr_mask,
    output logic            head_valid,
    output logic [PW-1:0]   head_data,
    output logic [CW-1:0]   count
);
    logic          ent_v [DEPTH];
    spec_state_t   ent_s [DEPTH];
    logic [PW-1:0] ent_d [DEPTH];
    logic          nxt_v [DEPTH];
    spec_state_t   nxt_s [DEPTH];
    logic [PW-1:0] nxt_d [DEPTH];
    logic          keep  [DEPTH];
    spec_state_t   cl_s  [DEPTH];
    int            rank  [DEPTH];
    int            kept;
    logic          pop_fire;

    // a head being killed this cycle is hidden at once, so it can never be popped
    assign head_valid = ent_v[0] && !spec_killed(ent_s[0], kill_valid, kill_mask);
    assign head_data  = ent_d[0];
    assign pop_fire   = head_valid && pop_ready;

    always_comb begin
        kept = 0;
        for (int i = 0; i < DEPTH; i++) begin
            cl_s[i] = spec_clear(ent_s[i], clr_valid, clr_mask);
            keep[i] = ent_v[i] && !spec_killed(ent_s[i], kill_valid, kill_mask) && !(i == 0 && pop_fire);
            rank[i] = kept;
            if (keep[i]) kept = kept + 1;
        end
        for (int j = 0; j < DEPTH; j++) begin
            nxt_v[j] = 1'b0;
            nxt_s[j] = '0;
            nxt_d[j] = ent_d[j];
            for (int i = 0; i < DEPTH; i++) begin
                if (keep[i] && rank[i] == j) begin
                    nxt_v[j] = 1'b1;
                    nxt_s[j] = cl_s[i];
                    nxt_d[j] = ent_d[i];
                end
            end
            if (push_valid && kept == j) begin
                nxt_v[j] = 1'b1;
                nxt_s[j] = push_spec;
                nxt_d[j] = push_data;
            end
        end
    end

    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) count = count + CW'(ent_v[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_v[i] <= 1'b0;
                ent_s[i] <= '0;
                ent_d[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_v[i] <= nxt_v[i];
                ent_s[i] <= nxt_s[i];
                ent_d[i] <= nxt_d[i];
            end
        end
    end
endmodule

// File: rtl/exunit_branch_pipe.sv
// rtl/exunit_branch_pipe.sv - pipelined branch/jump execution unit with credit-based issue and kill/clear
module exunit_branch_pipe
    import exunit_branch_pipe_pkg::*;
#(
    parameter int DATA_LEN   = 32,
    parameter int ADDR_LEN   = 32,
    parameter int STAGES     = 2,
    parameter int OUTQ_DEPTH = 2,
    parameter int RVC_EN     = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    exunit_branch_pipe_if.slave  bus
);
    localparam int PW = $bits(brq_meta_t) + DATA_LEN + 2 * ADDR_LEN;
    localparam int PD = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int CW = $clog2(OUTQ_DEPTH) + 2;

    logic                is_jal, is_jalr, cmp, brc;
    logic [ADDR_LEN-1:0] base, taken, fall, jmp;
    brq_meta_t           iss_meta;
    logic [PW-1:0]       iss_data;
    spec_state_t         iss_spec_raw, iss_spec;
    logic                iss_fire, iss_keep;
    logic                push_valid;
    spec_state_t         push_spec;
    logic [PW-1:0]       push_data;
    logic [CW-1:0]       pipe_cnt, fifo_cnt;
    logic                hv;
    logic [PW-1:0]       hdata;
    brq_meta_t           hmeta;
    logic [DATA_LEN-1:0] hres;
    logic [ADDR_LEN-1:0] hjmp, htaken;

    always_comb begin
        cmp = 1'b0;
        case (alu_op_t'(bus.alu_op))
            ALU_SEQ:  cmp = bus.ex_src1 == bus.ex_src2;
            ALU_SNE:  cmp = bus.ex_src1 != bus.ex_src2;
            ALU_SLT:  cmp = $signed(bus.ex_src1) <  $signed(bus.ex_src2);
            ALU_SGE:  cmp = $signed(bus.ex_src1) >= $signed(bus.ex_src2);
            ALU_SLTU: cmp = bus.ex_src1 <  bus.ex_src2;
            ALU_SGEU: cmp = bus.ex_src1 >= bus.ex_src2;
            default:  cmp = 1'b0;
        endcase
    end

    // all compute happens at issue; later stages only carry and filter the entry
    assign is_jal  = bus.opcode == RV32_JAL;
    assign is_jalr = bus.opcode == RV32_JALR;
    assign base    = is_jalr ? bus.ex_src1[ADDR_LEN-1:0] : bus.pc;
    assign taken   = (base + bus.imm[ADDR_LEN-1:0]) & ~ADDR_LEN'(is_jalr);
    assign fall    = bus.pc + ((RVC_EN != 0 && bus.is_rvc) ? ADDR_LEN'(2) : ADDR_LEN'(4));
    assign brc     = is_jal | is_jalr | cmp;
    assign jmp     = brc ? taken : fall;

    assign iss_meta     = '{owntag: bus.spectag, rrftag: bus.rrftag, dstval: bus.dstval,
                            brcond: brc, prsuccess: (jmp == bus.praddr)};
    assign iss_data     = {iss_meta, DATA_LEN'(fall), jmp, taken};
    assign iss_spec_raw = '{specbit: bus.specbit, mask: bus.spectag};
    assign iss_spec     = spec_clear(iss_spec_raw, bus.clr_valid, bus.clr_mask);
    assign iss_fire     = bus.issue_valid && bus.issue_ready;
    assign iss_keep     = iss_fire && !spec_killed(iss_spec_raw, bus.kill_valid, bus.kill_mask);

    // in-flight plus queued entries never exceed the queue depth, so the pipe never stalls
    assign bus.issue_ready = (pipe_cnt + fifo_cnt) < CW'(OUTQ_DEPTH);

    if (STAGES == 1) begin : g_direct
        assign push_valid = iss_keep;
        assign push_spec  = iss_spec;
        assign push_data  = iss_data;
        assign pipe_cnt   = '0;
    end else begin : g_pipe
        logic          st_v    [PD];
        spec_state_t   st_s    [PD];
        logic [PW-1:0] st_d    [PD];
        logic          st_keep [PD];
        spec_state_t   st_cl   [PD];

        always_comb begin
            pipe_cnt = '0;
            for (int i = 0; i < PD; i++) begin
                st_keep[i] = st_v[i] && !spec_killed(st_s[i], bus.kill_valid, bus.kill_mask);
                st_cl[i]   = spec_clear(st_s[i], bus.clr_valid, bus.clr_mask);
                pipe_cnt   = pipe_cnt + CW'(st_v[i]);
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < PD; i++) begin
                    st_v[i] <= 1'b0;
                    st_s[i] <= '0;
                    st_d[i] <= '0;
                end
            end else begin
                st_v[0] <= iss_keep;
                st_s[0] <= iss_spec;
                if (iss_fire) st_d[0] <= iss_data;
                for (int i = 1; i < PD; i++) begin
                    st_v[i] <= st_keep[i-1];
                    st_s[i] <= st_cl[i-1];
                    st_d[i] <= st_d[i-1];
                end
            end
        end

        assign push_valid = st_keep[PD-1];
        assign push_spec  = st_cl[PD-1];
        assign push_data  = st_d[PD-1];
    end

    exunit_branch_pipe_brq_killfifo #(.DEPTH(OUTQ_DEPTH), .PW(PW), .CW(CW)) u_brq (
        .clk        (clk),
        .reset      (reset),
        .push_valid (push_valid),
        .push_spec  (push_spec),
        .push_data  (push_data),
        .pop_ready  (bus.out_ready),
        .kill_valid (bus.kill_valid),
        .kill_mask  (bus.kill_mask),
        .clr_valid  (bus.clr_valid),
        .clr_mask   (bus.clr_mask),
        .head_valid (hv),
        .head_data  (hdata),
        .count      (fifo_cnt)
    );

    assign {hmeta, hres, hjmp, htaken} = hdata;

    assign bus.out_valid     = hv;
    assign bus.rob_we        = hv;
    assign bus.rrf_we        = hv & hmeta.dstval;
    assign bus.prsuccess     = hv & hmeta.prsuccess;
    assign bus.prmiss        = hv & ~hmeta.prsuccess;
    assign bus.brcond        = hv & hmeta.brcond;
    assign bus.result        = hv ? hres : '0;
    assign bus.jmpaddr       = hv ? hjmp : '0;
    assign bus.jmpaddr_taken = hv ? htaken : '0;
    assign bus.out_rrftag    = hv ? hmeta.rrftag : '0;
    assign bus.tagregfix     = hv ? {hmeta.owntag[0], hmeta.owntag[SPECTAG_LEN-1:1]} : '0;
endmodule

// File: doc/exunit_branch_pipe.md
Name: exunit_branch_pipe

Overview:
- Next-generation branch/jump execution unit for the out-of-order core; replaces the single-cycle, always-accept branch unit.
- Adds a configurable compute pipeline, a valid/ready output queue toward the ROB/RRF writeback arbiter, and speculative-tag kill/clear while instructions are in flight.
- Optional RVC link-address mode.
- Sits between the branch reservation station (issue side) and the writeback/misprediction-recovery logic.

Parameters:
- DATA_LEN, 32, operand/result width
- ADDR_LEN, 32, PC width
- SPECTAG_LEN, 5, one-hot speculative tag width
- RRF_SEL, 6, rename register tag width
- STAGES, 2, compute latency in cycles, legal 1..3
- OUTQ_DEPTH, 2, output queue entries, power of 2, ≥2
- RVC_EN, 0, 1 = link/fall-through is pc+2 when is_rvc is set

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- issue_valid  in  1  instruction presented
- issue_ready  out  1  unit can accept this cycle
- ex_src1, ex_src2  in  DATA_LEN  operands
- pc, praddr  in  ADDR_LEN  instruction PC, predicted target
- imm  in  DATA_LEN  offset
- opcode  in  7  RV32 opcode
- alu_op  in  ALU_OP_WIDTH  compare operation
- is_rvc  in  1  16-bit instruction
- dstval  in  1  writes rd
- rrftag  in  RRF_SEL  destination tag
- spectag  in  SPECTAG_LEN  own one-hot tag
- specbit  in  1  issued under speculation
- kill_valid  in  1  misprediction broadcast
- kill_mask  in  SPECTAG_LEN  tags to squash
- clr_valid  in  1  prediction-success broadcast
- clr_mask  in  SPECTAG_LEN  tags resolved correct
- out_valid  out  1  head entry valid
- out_ready  in  1  writeback accepts head
- result  out  DATA_LEN  link value
- out_rrftag  out  RRF_SEL  destination tag
- rrf_we, rob_we  out  1  out_valid&dstval, out_valid
- prsuccess, prmiss  out  1  qualified by out_valid
- jmpaddr, jmpaddr_taken  out  ADDR_LEN  resolved target, taken target
- brcond  out  1  taken
- tagregfix  out  SPECTAG_LEN  spectag rotated right by 1

Behaviour:
- Reset: all pipeline/queue valid bits 0.
  - out_valid, rrf_we, rob_we, prsuccess, prmiss = 0.
  - issue_ready = 1.
  - Data outputs are don't-care but driven to 0.
- Accept: transfer when issue_valid & issue_ready.
  - issue_ready = (occupied pipe slots + queue count) < OUTQ_DEPTH.
  - This credit count guarantees no in-flight entry ever stalls inside the pipe.
- Compute:
  - taken target = (opcode==JALR ? ex_src1 : pc) + imm.
  - For JALR, clear bit 0 of the target.
  - fallthrough = pc + (RVC_EN & is_rvc ? 2 : 4).
  - brcond = 1 for JAL/JALR, else compare bit 0.
  - jmpaddr = brcond ? taken : fallthrough.
  - result = fallthrough.
  - Adds wrap modulo 2^ADDR_LEN.
- Latency: an accepted instruction enters the queue after STAGES cycles.
  - out_valid is visible in cycle STAGES after the accept cycle, when the queue is empty.
  - Compute may be placed at any stage.
- Queue: FIFO with head presented on the outputs. Pop on out_valid & out_ready; ordering is preserved.
- Kill: on kill_valid, every pipe/queue entry with specbit & |(spectag_entry & kill_mask) is invalidated in that cycle.
  - An entry being issued in the same cycle is checked against the kill too and is not accepted if it matches.
  - Killed queue entries are compacted: the queue is head-ordered and unkilled survivors keep their order.
  - A killed head drops out_valid in that same cycle (combinational qualification), even if out_ready is high.
- Clear: on clr_valid, spectag_entry &= ~clr_mask for all entries and for the entry being issued.
  - Matching entries' specbit clears.
  - Kill has priority when both broadcasts hit the same entry in the same cycle.
- tagregfix and prsuccess/prmiss use the stored own-tag, which is held separately and not cleared by clr.
- Simultaneous push + pop while full: legal only via the credit count.
- Asynchronous reset mid-operation: all entries are dropped immediately and outputs return to reset values.

Decomposition:
- Shared package/header holds:
  - opcode constants (RV32_JAL, RV32_JALR)
  - ALU op encodings
  - SPECTAG_LEN, RRF_SEL
  - an entry struct/field-width constant set: tags, targets, flags
- One natural sub-module: brq_killfifo, a kill-capable compacting FIFO of OUTQ_DEPTH entries with per-entry spec masks.
- Reuse the existing alu as the comparator.

Test Plan:
- BEQ, src1=src2=5, pc=0x100, imm=0x20, praddr=0x120, STAGES=2, out_ready=1 -> 2 cycles later: out_valid=1, brcond=1, jmpaddr=0x120, prsuccess=1, result=0x104.
- JALR, src1=0x2001, imm=4, praddr=0x104 -> jmpaddr=0x2004, prmiss=1, rrf_we=dstval.
- RVC_EN=1, BNE not taken, is_rvc=1, pc=0x200 -> jmpaddr=0x202, result=0x202.
- out_ready=0 with 2 issues back-to-back, OUTQ_DEPTH=2 -> third issue sees issue_ready=0; release out_ready -> in-order drain, one entry per cycle.
- Two queued entries with spectags 00010 and 00100 (specbit=1), kill_mask=00010 -> first dropped same cycle, second becomes head; clr_mask=00100 on the survivor -> specbit clears, entry survives a later kill of 00100.
- Assert reset low while 2 entries are in flight -> out_valid=0 immediately, issue_ready=1 after release, no stale outputs.
